// File: rtl/uctl_ahb_mst_arb.sv
// uctl_ahb_mst_arb: arbitrates the DMA Tx and Rx burst requesters onto the single AHB master core.
// Ports:
//   uctl_sysClk / uctl_sysRst       clock, synchronous active-high reset
//   tx2arb_* / rx2arb_*             burst requests (trEn pulse, beats, hSize, address, direction)
//   arb2tx_* / arb2rx_*             ack, addrDn and dataDn routed back to the matching requester
//   arb2ahbc_* / ahbc2arb_*         muxed request to the AHB master core and its responses
//   arb_owner                       current burst owner: 00 none, 01 Tx, 10 Rx
// Build option: define UCTL_ARB_RX_PRIO_EN for Rx fixed priority with a Tx anti-starvation limit;
// the default build is plain round robin.
module uctl_ahb_mst_arb #(
  parameter int ADDR_SIZE     = 32,
  parameter int RX_MAX_CONSEC = 4
) (
  input  logic                 uctl_sysClk,
  input  logic                 uctl_sysRst,
  input  logic                 tx2arb_trEn,
  input  logic [4:0]           tx2arb_beats,
  input  logic [2:0]           tx2arb_hSize,
  input  logic [ADDR_SIZE-1:0] tx2arb_sRdAddr,
  input  logic                 tx2arb_sRdWr,
  output logic                 arb2tx_ack,
  output logic                 arb2tx_addrDn,
  output logic                 arb2tx_dataDn,
  input  logic                 rx2arb_trEn,
  input  logic [4:0]           rx2arb_beats,
  input  logic [2:0]           rx2arb_hSize,
  input  logic [ADDR_SIZE-1:0] rx2arb_sRdAddr,
  input  logic                 rx2arb_sRdWr,
  output logic                 arb2rx_ack,
  output logic                 arb2rx_addrDn,
  output logic                 arb2rx_dataDn,
  output logic                 arb2ahbc_trEn,
  output logic [4:0]           arb2ahbc_beats,
  output logic [2:0]           arb2ahbc_hSize,
  output logic [ADDR_SIZE-1:0] arb2ahbc_sRdAddr,
  output logic                 arb2ahbc_sRdWr,
  input  logic                 ahbc2arb_ack,
  input  logic                 ahbc2arb_addrDn,
  input  logic                 ahbc2arb_dataDn,
  output logic [1:0]           arb_owner
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_XFER} arb_state_e;
  localparam logic [1:0] OWN_NONE = 2'b00, OWN_TX = 2'b01, OWN_RX = 2'b10;
  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d, last_owner_q, last_owner_d;
  logic       pend_tx_q, pend_tx_d, pend_rx_q, pend_rx_d, tren_q, tren_d;
  logic       own_tx, own_rx, req_ack, win_rx;
`ifdef UCTL_ARB_RX_PRIO_EN
  logic [3:0] consec_q, consec_d;
  // Rx wins unless Tx has waited through RX_MAX_CONSEC consecutive Rx grants
  assign win_rx = pend_rx_q && !(pend_tx_q && consec_q >= 4'(RX_MAX_CONSEC));
`else
  logic       rr_ptr_q, rr_ptr_d;
  // rr_ptr_q set means Rx holds the round-robin turn
  assign win_rx = pend_rx_q && (!pend_tx_q || rr_ptr_q);
`endif
  assign own_tx  = owner_q == OWN_TX;
  assign own_rx  = owner_q == OWN_RX;
  assign req_ack = state_q == ARB_REQ && ahbc2arb_ack;
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tren_d       = 1'b0;
`ifdef UCTL_ARB_RX_PRIO_EN
    consec_d     = consec_q;
`else
    rr_ptr_d     = rr_ptr_q;
`endif
    // a trEn coinciding with its own release re-arms the pending bit
    pend_tx_d    = tx2arb_trEn | (pend_tx_q & ~(req_ack & own_tx));
    pend_rx_d    = rx2arb_trEn | (pend_rx_q & ~(req_ack & own_rx));
    case (state_q)
      ARB_IDLE: if (pend_tx_q || pend_rx_q) begin
        owner_d      = win_rx ? OWN_RX : OWN_TX;
        last_owner_d = win_rx ? OWN_RX : OWN_TX;
        tren_d       = 1'b1;
        state_d      = ARB_REQ;
`ifdef UCTL_ARB_RX_PRIO_EN
        consec_d     = (win_rx && pend_tx_q) ? consec_q + 4'd1 : 4'd0;
`else
        rr_ptr_d     = ~win_rx;
`endif
      end
      ARB_REQ: if (ahbc2arb_ack) begin
        state_d = ahbc2arb_addrDn ? ARB_IDLE : ARB_XFER;
        owner_d = ahbc2arb_addrDn ? OWN_NONE : owner_q;
      end
      ARB_XFER: if (ahbc2arb_addrDn) begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge uctl_sysClk) begin
    if (uctl_sysRst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_NONE;
      last_owner_q <= OWN_NONE;
      pend_tx_q    <= 1'b0;
      pend_rx_q    <= 1'b0;
      tren_q       <= 1'b0;
`ifdef UCTL_ARB_RX_PRIO_EN
      consec_q     <= 4'd0;
`else
      rr_ptr_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      pend_tx_q    <= pend_tx_d;
      pend_rx_q    <= pend_rx_d;
      tren_q       <= tren_d;
`ifdef UCTL_ARB_RX_PRIO_EN
      consec_q     <= consec_d;
`else
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end
  assign arb_owner        = owner_q;
  assign arb2ahbc_trEn    = tren_q;
  assign arb2ahbc_beats   = own_tx ? tx2arb_beats   : own_rx ? rx2arb_beats   : '0;
  assign arb2ahbc_hSize   = own_tx ? tx2arb_hSize   : own_rx ? rx2arb_hSize   : '0;
  assign arb2ahbc_sRdAddr = own_tx ? tx2arb_sRdAddr : own_rx ? rx2arb_sRdAddr : '0;
  assign arb2ahbc_sRdWr   = own_tx ? tx2arb_sRdWr   : own_rx ? rx2arb_sRdWr   : 1'b0;
  // owner is only non-zero in ARB_REQ/ARB_XFER, so stray responses are dropped here
  assign arb2tx_ack       = ahbc2arb_ack & own_tx;
  assign arb2rx_ack       = ahbc2arb_ack & own_rx;
  assign arb2tx_addrDn    = ahbc2arb_addrDn & own_tx;
  assign arb2rx_addrDn    = ahbc2arb_addrDn & own_rx;
  // dataDn trails the address phase, so it follows the most recent grant
  assign arb2tx_dataDn    = ahbc2arb_dataDn & (last_owner_q == OWN_TX);
  assign arb2rx_dataDn    = ahbc2arb_dataDn & (last_owner_q == OWN_RX);
endmodule

// File: tb/tb_uctl_ahb_mst_arb.sv
// tb_uctl_ahb_mst_arb: directed scenarios plus random traffic checked against a cycle reference model.
module tb_uctl_ahb_mst_arb;
  localparam int AW = 32, RXM = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic tx_tren = 0, tx_rdwr = 0, rx_tren = 0, rx_rdwr = 0, ack = 0, adn = 0, ddn = 0;
  logic [4:0] tx_beats = 0, rx_beats = 0, o_beats;
  logic [2:0] tx_hsize = 0, rx_hsize = 0, o_hsize;
  logic [AW-1:0] tx_addr = 0, rx_addr = 0, o_addr;
  logic o_tren, o_rdwr, tx_ack_o, tx_adn_o, tx_ddn_o, rx_ack_o, rx_adn_o, rx_ddn_o;
  logic [1:0] owner_o;
  int n_cmp = 0, n_err = 0;
  bit m_pend[3];
  bit m_tren;
  int m_owner, m_phase, m_last, m_fav = 1, m_consec;
  always #5 clk = ~clk;
  uctl_ahb_mst_arb #(.ADDR_SIZE(AW), .RX_MAX_CONSEC(RXM)) dut (
    .uctl_sysClk(clk), .uctl_sysRst(rst),
    .tx2arb_trEn(tx_tren), .tx2arb_beats(tx_beats), .tx2arb_hSize(tx_hsize),
    .tx2arb_sRdAddr(tx_addr), .tx2arb_sRdWr(tx_rdwr),
    .arb2tx_ack(tx_ack_o), .arb2tx_addrDn(tx_adn_o), .arb2tx_dataDn(tx_ddn_o),
    .rx2arb_trEn(rx_tren), .rx2arb_beats(rx_beats), .rx2arb_hSize(rx_hsize),
    .rx2arb_sRdAddr(rx_addr), .rx2arb_sRdWr(rx_rdwr),
    .arb2rx_ack(rx_ack_o), .arb2rx_addrDn(rx_adn_o), .arb2rx_dataDn(rx_ddn_o),
    .arb2ahbc_trEn(o_tren), .arb2ahbc_beats(o_beats), .arb2ahbc_hSize(o_hsize),
    .arb2ahbc_sRdAddr(o_addr), .arb2ahbc_sRdWr(o_rdwr),
    .ahbc2arb_ack(ack), .ahbc2arb_addrDn(adn), .ahbc2arb_dataDn(ddn),
    .arb_owner(owner_o)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic quiet();
    tx_tren = 0; rx_tren = 0; ack = 0; adn = 0; ddn = 0;
  endtask
  // one clock cycle: compare outputs for the current inputs, advance the model, cross the edge
  task automatic step();
    int win, clr;
    #1;
    check("trEn", o_tren, m_tren);
    check("owner", owner_o, m_owner);
    check("beats", o_beats, m_owner == 1 ? tx_beats : m_owner == 2 ? rx_beats : 5'd0);
    check("hsize", o_hsize, m_owner == 1 ? tx_hsize : m_owner == 2 ? rx_hsize : 3'd0);
    check("addr", o_addr, m_owner == 1 ? tx_addr : m_owner == 2 ? rx_addr : '0);
    check("rdwr", o_rdwr, m_owner == 1 ? tx_rdwr : m_owner == 2 ? rx_rdwr : 1'b0);
    check("resp", {tx_ack_o, tx_adn_o, tx_ddn_o, rx_ack_o, rx_adn_o, rx_ddn_o},
          {ack && m_owner == 1, adn && m_owner == 1, ddn && m_last == 1,
           ack && m_owner == 2, adn && m_owner == 2, ddn && m_last == 2});
    if (rst) begin
      m_pend[1] = 0; m_pend[2] = 0; m_tren = 0;
      m_owner = 0; m_phase = 0; m_last = 0; m_fav = 1; m_consec = 0;
    end else begin
      win = 0;
      if (m_phase == 0 && (m_pend[1] || m_pend[2])) begin
`ifdef UCTL_ARB_RX_PRIO_EN
        win = (m_pend[2] && !(m_pend[1] && m_consec >= RXM)) ? 2 : 1;
        m_consec = (win == 2 && m_pend[1]) ? m_consec + 1 : 0;
`else
        win = (m_pend[1] && m_pend[2]) ? m_fav : (m_pend[1] ? 1 : 2);
        m_fav = 3 - win;
`endif
      end
      clr = (m_phase == 1 && ack) ? m_owner : 0;
      m_pend[1] = tx_tren || (m_pend[1] && clr != 1);
      m_pend[2] = rx_tren || (m_pend[2] && clr != 2);
      m_tren = win != 0;
      if (win != 0) begin
        m_owner = win; m_last = win; m_phase = 1;
      end else if (m_phase == 1 && ack) begin
        m_phase = adn ? 0 : 2;
        if (adn) m_owner = 0;
      end else if (m_phase == 2 && adn) begin
        m_phase = 0; m_owner = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    quiet(); rst = 1; step(); step(); rst = 0;
  endtask
  initial begin
    int exp_own;
    bit seen;
    @(posedge clk);
    @(negedge clk);
    do_reset();
    check("rst_owner", owner_o, 0);
    check("rst_tren", o_tren, 0);
    // Tx-only burst
    tx_beats = 5'd16; tx_hsize = 3'b010; tx_addr = 32'h1000_0000; tx_rdwr = 1;
    tx_tren = 1; step(); quiet(); step();
    check("t1_tren", o_tren, 1);
    check("t1_addr", o_addr, 32'h1000_0000);
    check("t1_beats", o_beats, 16);
    check("t1_owner", owner_o, 1);
    step(); step(); step();
    ack = 1; #1 check("t1_ack", {tx_ack_o, rx_ack_o}, 2'b10); step(); quiet();
    step(); step(); step();
    adn = 1; #1 check("t1_adn", {tx_adn_o, rx_adn_o}, 2'b10); step(); quiet();
    check("t1_release", owner_o, 0);
    step();
    // ack+addrDn together, then dataDn after the next grant goes to the newest owner
    do_reset();
    rx_addr = 32'h2000_0040; rx_beats = 5'd4; rx_hsize = 3'b001; rx_rdwr = 0;
    tx_tren = 1; rx_tren = 1; step(); quiet(); step();
`ifndef UCTL_ARB_RX_PRIO_EN
    check("t3_first", owner_o, 1);
    ack = 1; adn = 1; step(); quiet();
    check("t3_gap1", o_tren, 0);
    step();
    check("t3_gap2", o_tren, 1);
    check("t3_owner", owner_o, 2);
    ddn = 1; #1 check("t4_ddn", {tx_ddn_o, rx_ddn_o}, 2'b01); step(); quiet();
`endif
    ack = 1; adn = 1; step(); quiet(); step(); step();
    // back-to-back continuous requests from both sides
    do_reset();
    tx_addr = 32'hA000_0000; rx_addr = 32'hB000_0000;
    tx_tren = 1; rx_tren = 1; step(); quiet();
    for (int k = 0; k < 10; k++) begin
      seen = 0;
      for (int w = 0; w < 10 && !seen; w++) begin
        if (o_tren) seen = 1; else step();
      end
      check("t2_grant_seen", seen, 1);
`ifdef UCTL_ARB_RX_PRIO_EN
      exp_own = (k % 5 == 4) ? 1 : 2;
`else
      exp_own = (k % 2 == 1) ? 2 : 1;
`endif
      check("t2_owner", owner_o, exp_own);
      check("t2_addr", o_addr, exp_own == 1 ? 32'hA000_0000 : 32'hB000_0000);
      ack = 1; adn = 1;
      if (owner_o == 2'b01) tx_tren = 1; else rx_tren = 1;
      step(); quiet();
    end
    // reset while in the data phase with Rx pending
    do_reset();
    tx_tren = 1; step(); quiet(); step();
    rx_tren = 1; ack = 1; step(); quiet();
    step();
    rst = 1; step(); rst = 0;
    check("t5_owner", owner_o, 0);
    for (int k = 0; k < 4; k++) begin
      check("t5_no_tren", o_tren, 0);
      step();
    end
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      quiet();
      ack = m_phase == 1 ? ($urandom_range(0, 2) == 0) : (m_phase == 0 && $urandom_range(0, 7) == 0);
      adn = m_phase == 1 ? (ack && $urandom_range(0, 1) == 1)
                         : (m_phase == 2 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 7) == 0);
      ddn = $urandom_range(0, 5) == 0;
      if ((!m_pend[1] || (m_phase == 1 && ack && m_owner == 1)) && $urandom_range(0, 2) == 0) begin
        tx_tren = 1; tx_beats = 5'($urandom); tx_hsize = 3'($urandom); tx_addr = $urandom; tx_rdwr = 1'($urandom);
      end
      if ((!m_pend[2] || (m_phase == 1 && ack && m_owner == 2)) && $urandom_range(0, 2) == 0) begin
        rx_tren = 1; rx_beats = 5'($urandom); rx_hsize = 3'($urandom); rx_addr = $urandom; rx_rdwr = 1'($urandom);
      end
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uctl_ahb_mst_arb.md
Name: uctl_ahb_mst_arb

Overview:
- Shares the single AHB master core (ahbc) between two burst requesters: the DMA Tx control path and the DMA Rx control path.
- Each requester issues one burst request at a time (trEn pulse plus beats, hSize, address and RdWr).
- The arbiter latches requests, grants one owner per burst, and muxes the owner's burst attributes onto the ahbc request interface.
- It routes ack, addrDn and dataDn back to the correct requester. It sits between the ctrl blocks and the AHB master core.

Parameters:
ADDR_SIZE, 32, width of the system address bus.
RX_MAX_CONSEC, 4, consecutive Rx grants allowed before a pending Tx must be served (used only with the optional feature); legal range 1..15.

Ports:
uctl_sysClk  input  1  system clock, all logic on the rising edge
uctl_sysRst  input  1  synchronous, active-high reset
tx2arb_trEn  input  1  Tx burst request, one-cycle pulse
tx2arb_beats  input  5  Tx beats, stable until ack
tx2arb_hSize  input  3  Tx hSize, stable until ack
tx2arb_sRdAddr  input  ADDR_SIZE  Tx burst address, stable until ack
tx2arb_sRdWr  input  1  Tx direction, stable until ack
arb2tx_ack  output  1  ahbc ack, routed to Tx
arb2tx_addrDn  output  1  ahbc addrDn, routed to Tx
arb2tx_dataDn  output  1  ahbc dataDn, routed to Tx
rx2arb_trEn, rx2arb_beats, rx2arb_hSize, rx2arb_sRdAddr, rx2arb_sRdWr  input  1/5/3/ADDR_SIZE/1  Rx equivalents of the Tx request inputs
arb2rx_ack, arb2rx_addrDn, arb2rx_dataDn  output  1 each  Rx equivalents of the Tx response outputs
arb2ahbc_trEn  output  1  burst request to ahbc, one-cycle pulse
arb2ahbc_beats  output  5  muxed beats
arb2ahbc_hSize  output  3  muxed hSize
arb2ahbc_sRdAddr  output  ADDR_SIZE  muxed address
arb2ahbc_sRdWr  output  1  muxed direction
ahbc2arb_ack  input  1  ahbc accepted the request
ahbc2arb_addrDn  input  1  burst address phase complete
ahbc2arb_dataDn  input  1  burst data complete
arb_owner  output  2  current owner: 00 none, 01 Tx, 10 Rx

Behaviour:
Reset (uctl_sysRst=1 at a clock edge, including mid-burst):
- state = ARB_IDLE; owner = 00; last_owner = 00; pend_tx = pend_rx = 0; rr_ptr = Tx; consec counter = 0.
- All outputs read 0.

Request latching:
- pend_x is set on x2arb_trEn and cleared on ahbc2arb_ack while owner == x.
- A trEn while pend_x is already set is ignored.
- A trEn arriving in the same cycle as that requester's release is latched as a new pending request.

State ARB_IDLE:
- If any pend_x is set, select a winner and register owner = winner. arb2ahbc_trEn is a registered pulse in the next cycle. Go to ARB_REQ.
- Round robin: if both are pending, the winner is rr_ptr. rr_ptr then toggles to the loser. If only one is pending, it wins and rr_ptr points to the other.

State ARB_REQ: wait for ahbc2arb_ack.
- On ack: clear the owner's pend bit.
- If ahbc2arb_addrDn is high in the same cycle, go to ARB_IDLE and release owner (owner = 00).
- Otherwise go to ARB_XFER.

State ARB_XFER: on ahbc2arb_addrDn, go to ARB_IDLE and release owner.

Minimum spacing:
- Release to the next arb2ahbc_trEn is 2 cycles: release edge, then the decision registered in ARB_IDLE.
- The first grant is 2 cycles after the trEn pulse.

Muxing:
- arb2ahbc_beats, hSize, sRdAddr and sRdWr are combinational from the owner register. All are 0 when owner = 00.
- ack and addrDn are routed combinationally to the owner only; the non-owner sees 0.

dataDn routing:
- last_owner is loaded with the winner at each grant.
- ahbc2arb_dataDn is routed to last_owner, so a dataDn arriving after release still reaches the correct requester.
- dataDn while last_owner = 00 is dropped.

Spurious events:
- ack or addrDn outside ARB_REQ/ARB_XFER is ignored and not forwarded.

Optional Feature:
Macro UCTL_ARB_RX_PRIO_EN.
- Defined: Rx has fixed priority over Tx.
- A 4-bit counter counts consecutive Rx grants while pend_tx = 1.
- When the counter reaches RX_MAX_CONSEC, the next decision with Tx pending goes to Tx and the counter clears.
- The counter also clears on any Tx grant, or on an Rx grant while pend_tx = 0.
- rr_ptr is unused in this mode.
- Undefined: pure round robin as described above; the counter is not built.

Test Plan:
1. Tx-only burst: tx trEn with beats=16, hSize=010, addr=0x1000_0000; ack 3 cycles later, addrDn 4 cycles after that.
   -> arb2ahbc_trEn pulses 2 cycles after tx trEn with matching attributes; arb2tx_ack and arb2tx_addrDn are forwarded; arb_owner goes 01 then 00; rx outputs stay 0.
2. Simultaneous tx and rx trEn, four back-to-back bursts each.
   -> Grants go Tx, Rx, Tx, Rx...; each arb2ahbc_trEn carries the owner's address.
3. ack and addrDn in the same cycle.
   -> Direct ARB_REQ to ARB_IDLE; the next grant's trEn comes exactly 2 cycles later.
4. Tx burst released, then Rx granted, then ahbc2arb_dataDn for the Tx burst.
   -> The most recent grant went to Rx, so last_owner = Rx and dataDn routes to arb2rx_dataDn, not to Tx. This documents the single-outstanding assumption.
5. Reset asserted in ARB_XFER with pend_rx set.
   -> The cycle after reset, all outputs read 0, owner = 00, and no trEn is issued until a new request arrives.
6. With UCTL_ARB_RX_PRIO_EN and RX_MAX_CONSEC=4, continuous Rx and Tx requests.
   -> Grants go Rx, Rx, Rx, Rx, Tx, repeating.
